ssd_bcd_display_driver: RTL and testbench

- Downstream consumer of the CPU top-level 13-bit seven-segment value (SSG_out) on the Nexys A7.
- Converts the unsigned binary value to 4-digit BCD with a sequential double-dabble engine (one shift per clock).
- Time-multiplexes the four digits onto the board's common-anode display using a refresh counter.
- All outputs are active-low for the anode and cathode pins, matching the board.

---
 rtl/ssd_bcd_display_driver.sv | 163 ++++++++++++++++
 tb/tb_ssd_bcd_display_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ssd_bcd_display_driver.sv
// Binary-to-BCD converter (serial double-dabble) driving a
// 4-digit common-anode seven-segment display, all pins active-low.
module ssd_bcd_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value_in,
  output logic [15:0] bcd_out,
  output logic        valid,
  output logic        busy,
  output logic [1:0]  digit_sel,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t      r_state, w_state_nx;
  logic [12:0] r_shift, w_shift_nx;
  logic [15:0] r_work,  w_work_nx;
  logic [3:0]  r_cnt,   w_cnt_nx;
  logic        r_pend,  w_pend_nx;
  logic [12:0] r_last,  w_last_nx;
  logic [15:0] r_bcd,   w_bcd_nx;
  logic        r_valid, w_valid_nx;
  logic        r_busy,  w_busy_nx;
  logic [15:0] w_adj;
  logic [15:0] w_work_sh;

  logic [RW-1:0] r_rcnt;
  logic [1:0]    r_sel;
  logic [3:0]    w_nib;
  logic          w_blank;

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 4; i++) begin
      if (r_work[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
  end

  assign w_work_sh = {w_adj[14:0], r_shift[12]};

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_work_nx  = r_work;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_last_nx  = r_last;
    w_bcd_nx   = r_bcd;
    w_valid_nx = 1'b0;
    w_busy_nx  = r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend || value_in != r_last) begin
          w_shift_nx = value_in;
          w_last_nx  = value_in;
          w_work_nx  = '0;
          w_cnt_nx   = '0;
          w_pend_nx  = 1'b0;
          w_busy_nx  = 1'b1;
          w_state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_work_nx  = w_work_sh;
        w_shift_nx = {r_shift[11:0], 1'b0};
        w_cnt_nx   = r_cnt + 4'd1;
        if (r_cnt == 4'd12) begin
          w_bcd_nx   = w_work_sh;
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b1;
      r_last  <= '0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_work  <= w_work_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_last  <= w_last_nx;
      r_bcd   <= w_bcd_nx;
      r_valid <= w_valid_nx;
      r_busy  <= w_busy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt <= '0;
      r_sel  <= '0;
    end else if (r_rcnt == R_LAST) begin
      r_rcnt <= '0;
      r_sel  <= r_sel + 2'd1;
    end else begin
      r_rcnt <= r_rcnt + RW'(1);
    end
  end

  // Blanking looks only at the committed result, never r_work.
  always_comb begin
    w_nib   = r_bcd[{r_sel, 2'b00} +: 4];
    w_blank = 1'b0;
    unique case (r_sel)
      2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
      2'd2:    w_blank = (r_bcd[15:8] == 8'd0);
      2'd1:    w_blank = (r_bcd[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end

  always_comb begin
    cathode = 7'b1111111;
    if (!(BLANK_LZ && w_blank)) begin
      case (w_nib)
        4'd0:    cathode = 7'b0000001;
        4'd1:    cathode = 7'b1001111;
        4'd2:    cathode = 7'b0010010;
        4'd3:    cathode = 7'b0000110;
        4'd4:    cathode = 7'b1001100;
        4'd5:    cathode = 7'b0100100;
        4'd6:    cathode = 7'b0100000;
        4'd7:    cathode = 7'b0001111;
        4'd8:    cathode = 7'b0000000;
        4'd9:    cathode = 7'b0000100;
        default: cathode = 7'b1111111;
      endcase
    end
  end

  assign anode     = ~(4'b0001 << r_sel);
  assign digit_sel = r_sel;
  assign bcd_out   = r_bcd;
  assign valid     = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ssd_bcd_display_driver.sv
// Randomized bench for ssd_bcd_display_driver against a
// decimal-arithmetic reference model; both BLANK_LZ settings.
module tb_ssd_bcd_display_driver;

  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [12:0] value_in;
  logic [15:0] bcd_out, bcd_out0;
  logic        valid, valid0;
  logic        busy, busy0;
  logic [1:0]  digit_sel, digit_sel0;
  logic [3:0]  anode, anode0;
  logic [6:0]  cathode, cathode0;

  ssd_bcd_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in),
    .bcd_out(bcd_out), .valid(valid), .busy(busy),
    .digit_sel(digit_sel), .anode(anode), .cathode(cathode)
  );

  ssd_bcd_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .value_in(value_in),
    .bcd_out(bcd_out0), .valid(valid0), .busy(busy0),
    .digit_sel(digit_sel0), .anode(anode0), .cathode(cathode0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_busy = 0;

  int m_left, m_cap, m_last, m_disp, m_sel, m_rcnt;
  bit m_pend, m_valid;

  logic [6:0] seg_tab [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int pw [4] = '{1, 10, 100, 1000};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_cat(input int v, input int s,
                                         input bit blank);
    if (blank && s > 0 && v < pw[s]) return 7'b1111111;
    return seg_tab[(v / pw[s]) % 10];
  endfunction

  task automatic tick();
    if (rst) begin
      m_left = 0; m_disp = 0; m_valid = 0; m_pend = 1;
      m_last = 0; m_sel = 0; m_rcnt = 0;
    end else begin
      m_valid = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp = m_cap;
          m_valid = 1;
        end
      end else if (m_pend || int'(value_in) != m_last) begin
        m_cap = int'(value_in);
        m_last = m_cap;
        m_pend = 0;
        m_left = 13;
      end
      if (m_rcnt == RD - 1) begin
        m_rcnt = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_rcnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (valid) n_valid++;
    if (busy) n_busy++;
    chk("bcd_out", 32'(bcd_out), 32'(to_bcd(m_disp)));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("digit_sel", 32'(digit_sel), 32'(m_sel));
    chk("anode", 32'(anode), 32'(an_tab[m_sel]));
    chk("cathode", 32'(cathode), 32'(exp_cat(m_disp, m_sel, 1'b1)));
    chk("cathode_nb", 32'(cathode0), 32'(exp_cat(m_disp, m_sel, 1'b0)));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    value_in = '0;
    run(2);
    chk("rst_anode", 32'(anode), 32'(4'b1110));
    chk("rst_cathode", 32'(cathode), 32'(7'b0000001));
    rst = 1'b0;
    n_valid = 0; n_busy = 0;
    run(20);
    chk("zero_busy_w", 32'(n_busy), 32'd13);
    chk("zero_valid_n", 32'(n_valid), 32'd1);

    value_in = 13'd8191;
    n_valid = 0; n_busy = 0;
    run(20);
    chk("full_scale", 32'(bcd_out), 32'h8191);
    chk("fs_busy_w", 32'(n_busy), 32'd13);
    chk("fs_valid_n", 32'(n_valid), 32'd1);

    value_in = 13'd1234;
    run(20);
    chk("mux_bcd", 32'(bcd_out), 32'h1234);
    run(20);

    value_in = 13'd100;
    n_valid = 0;
    run(6);
    value_in = 13'd205;
    run(40);
    chk("chg_valid_n", 32'(n_valid), 32'd2);
    chk("chg_bcd", 32'(bcd_out), 32'h0205);

    value_in = 13'd42;
    run(20);
    chk("pre_rst_bcd", 32'(bcd_out), 32'h0042);
    value_in = 13'd777;
    run(8);
    rst = 1'b1;
    run(1);
    chk("mid_rst_bcd", 32'(bcd_out), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_anode", 32'(anode), 32'(4'b1110));
    rst = 1'b0;
    run(20);
    chk("reconv_bcd", 32'(bcd_out), 32'h0777);

    value_in = 13'd5;
    run(36);
    value_in = 13'd1000;
    run(36);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0)
        value_in = 13'($urandom_range(0, 8191));
      run($urandom_range(1, 6));
    end
    rst = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
